rr_decode_arbiter: RTL and testbench
====================================

# rr_decode_arbiter

Round-robin arbiter that shares one 8-way decoded resource (e.g. a bank/chip-select fan-out) among 8 requesters. It selects one requester at a time and presents the grant both as a 3-bit index, for the select-decoder input, and as the matching one-hot 8-bit grant. A grant is held until the owner releases it or a hold-timeout expires. One dead cycle separates consecutive grants.

## Interface
- MAX_HOLD, 15: maximum number of cycles a single grant may stay asserted; legal range 1..255. Hold counter width is $clog2(MAX_HOLD+1).
- clk  input  1  sole clock; all state updates on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req  input  8  level request; bit i is requester i.
- done  input  1  release strobe from the current grant owner; ignored unless state is GRANT.
- gnt  output  8  one-hot grant; equals the 3-to-8 decode of gnt_idx while gnt_valid=1, else 8'h00.
- gnt_idx  output  3  index of the current or most recent grantee.
- gnt_valid  output  1  high while in GRANT.
- timeout  output  1  one-cycle pulse when a grant is force-released by the hold limit.

## Operation
- States: IDLE, GRANT, GAP. All outputs are registered.
- Reset values: state=IDLE, ptr=0, hold_cnt=0, gnt=8'h00, gnt_idx=3'd0, gnt_valid=0, timeout=0.
- IDLE:
  - If req==0, stay in IDLE.
  - Otherwise select the first set bit of req scanning ptr, ptr+1, … modulo 8, wrapping 7→0.
  - Load gnt_idx with that index, clear hold_cnt and enter GRANT.
- GRANT:
  - release = done | ~req[gnt_idx].
  - If release, enter GAP, set ptr=gnt_idx+1 (mod 8) and leave timeout=0.
  - Else if hold_cnt==MAX_HOLD-1, enter GAP, set ptr=gnt_idx+1 and pulse timeout for 1 cycle, aligned with the GAP cycle.
  - Else increment hold_cnt.
  - If release and the limit occur in the same cycle, release wins: no timeout pulse.
- GAP: gnt=0 and gnt_valid=0 for exactly one cycle, then IDLE. Requests are not evaluated in GAP.
- Requests that appear or drop for non-owners during GRANT have no effect.
- gnt_idx holds its value through GAP and IDLE; only gnt and gnt_valid clear.
- Fairness: a continuously asserted requester is granted within 7 intervening grants.

## Timing
- Grant latency: req sampled in IDLE at edge N gives gnt, gnt_valid and gnt_idx valid after edge N (a 1-cycle registered response).
- Grant duration: 1..MAX_HOLD cycles.
  - done sampled at edge T: gnt drops after edge T. The done cycle itself counts as a granted cycle.
- Turnaround: release at edge T gives GAP after T and IDLE after T+1. The next gnt is asserted after edge T+2, so the minimum gap between grants is 2 cycles with gnt low.
- Back-to-back timeouts with MAX_HOLD=1: grant 1 cycle, GAP 1 cycle, IDLE 1 cycle, repeating.
- Asynchronous reset mid-GRANT clears gnt, gnt_valid and timeout immediately, without waiting for a clock edge. After rst_n deasserts, the first arbitration starts from ptr=0.
- No combinational path from any input to any output.

## Test plan
- Reset: hold rst_n=0 with req=8'hFF. Required: gnt=8'h00, gnt_valid=0, gnt_idx=0, timeout=0. After release, the first grant is gnt=8'h01.
- Single requester: req=8'h08 held, done pulsed on the 3rd grant cycle. Required: gnt=8'h08, gnt_idx=3 for 3 cycles, then 2 cycles of 8'h00, then 8'h08 again.
- Round-robin: req=8'hFF constant, done pulsed on each grant's first cycle. Required grant order: idx 0,1,2,3,4,5,6,7,0, with each grant separated by 2 idle-gnt cycles.
- Wrap: after a grant to idx 7 (ptr=0), set req=8'h41. Required: idx 0 (gnt=8'h01) first, then idx 6.
- Timeout, MAX_HOLD=4: req=8'h24, done never asserted. Required: gnt=8'h04 for exactly 4 cycles, then a timeout pulse in the GAP cycle, then gnt=8'h20.
- Release/limit collision: MAX_HOLD=4, done asserted on the 4th grant cycle. Required: timeout stays 0.
- Reset mid-grant: drop rst_n during GRANT of idx 5. Required: gnt=0 with no clock edge needed.

Source files
------------

// File: rtl/rr_decode_arbiter_if.sv
// rr_decode_arbiter_if
//   Request/grant bundle between 8 requesters and the round-robin decode arbiter.
//   req       [7:0] level request, bit i is requester i
//   done            release strobe from the current grant owner
//   gnt       [7:0] one-hot grant (decode of gnt_idx while gnt_valid)
//   gnt_idx   [2:0] index of the current or most recent grantee
//   gnt_valid       high while a grant is held
//   timeout         one-cycle pulse when a grant is force-released by the hold limit
//   master: requester side; slave: arbiter side.
interface rr_decode_arbiter_if;
    logic [7:0] req;
    logic       done;
    logic [7:0] gnt;
    logic [2:0] gnt_idx;
    logic       gnt_valid;
    logic       timeout;

    modport master (
        output req,
        output done,
        input  gnt,
        input  gnt_idx,
        input  gnt_valid,
        input  timeout
    );

    modport slave (
        input  req,
        input  done,
        output gnt,
        output gnt_idx,
        output gnt_valid,
        output timeout
    );
endinterface

// File: rtl/rr_decode_arbiter.sv
// rr_decode_arbiter
//   Round-robin arbiter sharing one 8-way decoded resource among 8 requesters.
//   Grants are held until the owner releases (done or request drop) or the
//   hold limit of MAX_HOLD cycles expires; one dead cycle (GAP) separates grants.
//   Ports:
//     clk    rising-edge clock
//     rst_n  asynchronous active-low reset
//     bus    rr_decode_arbiter_if.slave (req/done in, gnt/gnt_idx/gnt_valid/timeout out)
//   All outputs are registered.
module rr_decode_arbiter #(
    parameter int MAX_HOLD = 15
) (
    input  logic                   clk,
    input  logic                   rst_n,
    rr_decode_arbiter_if.slave     bus
);

    localparam int CW = $clog2(MAX_HOLD + 1);

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        GAP
    } state_t;

    state_t        state_q, state_d;
    logic [2:0]    ptr_q, ptr_d;
    logic [CW-1:0] hold_cnt_q, hold_cnt_d;
    logic [7:0]    gnt_q, gnt_d;
    logic [2:0]    gnt_idx_q, gnt_idx_d;
    logic          gnt_valid_q, gnt_valid_d;
    logic          timeout_q, timeout_d;

    logic [2:0]    sel_idx;
    logic          sel_found;
    logic [2:0]    cand;
    logic          release_w;
    logic          at_limit;

    // First set request scanning from ptr upward, wrapping 7 -> 0.
    always_comb begin
        sel_idx   = '0;
        sel_found = 1'b0;
        cand      = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            cand = ptr_q + 3'(i);
            if (!sel_found && bus.req[cand]) begin
                sel_found = 1'b1;
                sel_idx   = cand;
            end
        end
    end

    assign release_w = bus.done | ~bus.req[gnt_idx_q];
    assign at_limit  = (hold_cnt_q == CW'(MAX_HOLD - 1));

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        hold_cnt_d  = hold_cnt_q;
        gnt_d       = '0;
        gnt_idx_d   = gnt_idx_q;
        gnt_valid_d = 1'b0;
        timeout_d   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (sel_found) begin
                    state_d     = GRANT;
                    gnt_idx_d   = sel_idx;
                    hold_cnt_d  = '0;
                    gnt_d       = 8'b1 << sel_idx;
                    gnt_valid_d = 1'b1;
                end
            end
            GRANT: begin
                // Release has priority over the hold limit, so a release in
                // the limit cycle never produces a timeout pulse.
                if (release_w) begin
                    state_d = GAP;
                    ptr_d   = gnt_idx_q + 3'd1;
                end else if (at_limit) begin
                    state_d   = GAP;
                    ptr_d     = gnt_idx_q + 3'd1;
                    timeout_d = 1'b1;
                end else begin
                    hold_cnt_d  = hold_cnt_q + CW'(1);
                    gnt_d       = gnt_q;
                    gnt_valid_d = 1'b1;
                end
            end
            GAP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            hold_cnt_q  <= '0;
            gnt_q       <= '0;
            gnt_idx_q   <= '0;
            gnt_valid_q <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            hold_cnt_q  <= hold_cnt_d;
            gnt_q       <= gnt_d;
            gnt_idx_q   <= gnt_idx_d;
            gnt_valid_q <= gnt_valid_d;
            timeout_q   <= timeout_d;
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.gnt_idx   = gnt_idx_q;
    assign bus.gnt_valid = gnt_valid_q;
    assign bus.timeout   = timeout_q;

endmodule

// File: tb/tb_rr_decode_arbiter.sv
// tb_rr_decode_arbiter
//   Directed bench for rr_decode_arbiter with MAX_HOLD=4: reset, round-robin
//   order, wrap, single requester, request-drop release, timeout, release/limit
//   collision and asynchronous reset during a grant.
module tb_rr_decode_arbiter;

    logic clk;
    logic rst_n;

    int n_assert;
    int n_fail;

    rr_decode_arbiter_if bus ();

    rr_decode_arbiter #(
        .MAX_HOLD (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [7:0] g, input logic [2:0] idx,
                           input logic v, input logic to);
        chk({tag, ".gnt"},       32'(bus.gnt),       32'(g));
        chk({tag, ".gnt_idx"},   32'(bus.gnt_idx),   32'(idx));
        chk({tag, ".gnt_valid"}, 32'(bus.gnt_valid), 32'(v));
        chk({tag, ".timeout"},   32'(bus.timeout),   32'(to));
    endtask

    // Called in a grant cycle: checks the grant, releases it with done, checks
    // GAP and IDLE, applies next_req, and returns in the following grant cycle.
    task automatic grant_release(input string tag, input logic [2:0] idx, input logic [7:0] next_req);
        chk_out({tag, ".grant"}, 8'b1 << idx, idx, 1'b1, 1'b0);
        bus.done = 1'b1;
        tick();
        bus.done = 1'b0;
        bus.req  = next_req;
        chk_out({tag, ".gap"}, 8'h00, idx, 1'b0, 1'b0);
        tick();
        chk_out({tag, ".idle"}, 8'h00, idx, 1'b0, 1'b0);
        tick();
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        rst_n    = 1'b1;
        bus.req  = 8'hFF;
        bus.done = 1'b0;

        // Reset asserted before any clock edge: outputs clear asynchronously.
        #2 rst_n = 1'b0;
        #1 chk_out("reset_async", 8'h00, 3'd0, 1'b0, 1'b0);
        tick();
        tick();
        chk_out("reset_held", 8'h00, 3'd0, 1'b0, 1'b0);
        rst_n = 1'b1;
        tick();
        chk_out("first_grant", 8'h01, 3'd0, 1'b1, 1'b0);

        // Round-robin order 0..7,0 with all requesting; last leaves req=80.
        for (int k = 0; k < 9; k++) begin
            grant_release($sformatf("rr%0d", k), 3'(k % 8), (k == 8) ? 8'h80 : 8'hFF);
        end

        // Grant 7 leaves ptr=0; with req=41 expect idx 0 then idx 6.
        grant_release("wrap7", 3'd7, 8'h41);
        grant_release("wrap0", 3'd0, 8'h41);
        // ptr=7 after idx 6 -> scan 7,0,1,2,3 finds 3.
        grant_release("wrap6", 3'd6, 8'h08);

        // Single requester 3: 3 granted cycles, done on the 3rd.
        chk_out("single_c1", 8'h08, 3'd3, 1'b1, 1'b0);
        tick();
        chk_out("single_c2", 8'h08, 3'd3, 1'b1, 1'b0);
        tick();
        chk_out("single_c3", 8'h08, 3'd3, 1'b1, 1'b0);
        bus.done = 1'b1;
        tick();
        bus.done = 1'b0;
        chk_out("single_gap", 8'h00, 3'd3, 1'b0, 1'b0);
        tick();
        chk_out("single_idle", 8'h00, 3'd3, 1'b0, 1'b0);
        tick();
        chk_out("single_again", 8'h08, 3'd3, 1'b1, 1'b0);

        // Release by dropping the owner's request.
        bus.req = 8'h80;
        tick();
        chk_out("drop_gap", 8'h00, 3'd3, 1'b0, 1'b0);
        tick();
        chk_out("drop_idle", 8'h00, 3'd3, 1'b0, 1'b0);
        tick();
        grant_release("to_setup", 3'd7, 8'h24);

        // Timeout: ptr=0, req=24 -> idx 2 held exactly 4 cycles.
        for (int c = 1; c <= 4; c++) begin
            chk_out($sformatf("timeout_c%0d", c), 8'h04, 3'd2, 1'b1, 1'b0);
            tick();
        end
        chk_out("timeout_gap", 8'h00, 3'd2, 1'b0, 1'b1);
        tick();
        chk_out("timeout_idle", 8'h00, 3'd2, 1'b0, 1'b0);
        tick();
        chk_out("timeout_next", 8'h20, 3'd5, 1'b1, 1'b0);

        // Collision: done in the 4th (limit) cycle -> no timeout pulse.
        for (int c = 1; c <= 3; c++) begin
            chk_out($sformatf("coll_c%0d", c), 8'h20, 3'd5, 1'b1, 1'b0);
            tick();
        end
        chk_out("coll_c4", 8'h20, 3'd5, 1'b1, 1'b0);
        bus.done = 1'b1;
        tick();
        bus.done = 1'b0;
        chk_out("coll_gap", 8'h00, 3'd5, 1'b0, 1'b0);
        tick();
        chk_out("coll_idle", 8'h00, 3'd5, 1'b0, 1'b0);
        tick();
        // ptr=6 -> scan 6,7,0,1,2 finds 2, then ptr=3 finds 5.
        grant_release("coll_after", 3'd2, 8'h24);

        // Asynchronous reset in the middle of a grant to idx 5.
        chk_out("mid_c1", 8'h20, 3'd5, 1'b1, 1'b0);
        tick();
        chk_out("mid_c2", 8'h20, 3'd5, 1'b1, 1'b0);
        #2 rst_n = 1'b0;
        #1 chk_out("mid_reset", 8'h00, 3'd0, 1'b0, 1'b0);
        rst_n = 1'b1;
        tick();
        // ptr restarted at 0 -> idx 2 first.
        chk_out("post_reset", 8'h04, 3'd2, 1'b1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
